// File: rtl/beeb816_clk_pkg.sv
// Shared definitions for the CPU clock-speed controller: FSM state encoding,
// default decode/timing constants and a counter-width helper.
package beeb816_clk_pkg;

    // Controller state: settled on a clock (LS/HS) or waiting for the mux (SW_*).
    typedef enum logic [1:0] {
        LS    = 2'd0,
        SW_HS = 2'd1,
        HS    = 2'd2,
        SW_LS = 2'd3
    } clk_state_e;

    // Bank-0 pages decoded as slow IO.
    localparam logic [7:0]  IO_LO_DEF          = 8'hFC;
    localparam logic [7:0]  IO_HI_DEF          = 8'hFE;

    // Timing defaults.
    localparam int unsigned HOLD_CYCLES_DEF    = 4;
    localparam int unsigned SWITCH_TIMEOUT_DEF = 63;

    // Divider reset value and speed control register location.
    localparam logic [1:0]  DEFAULT_DIV_DEF    = 2'b00;
    localparam logic [23:0] DIVREG_ADDR_DEF    = 24'hFF00FF;

    // Bits needed for a counter that holds 0..max_val.
    function automatic int unsigned ctr_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/clk_sync2.sv
// Two-flop synchroniser for the latch-derived LS-clock acknowledge.
// Resets to 1 because the mux comes out of reset running the LS clock.
module clk_sync2 (
    input  logic cpuclk_r,
    input  logic rst_b,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Shift the asynchronous input through two flops.
    always_ff @(posedge cpuclk_r or negedge rst_b) begin
        if (!rst_b) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments let both flops sample their old
            // values on the same edge; blocking here would collapse the chain.
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/hsclk_sel_ctrl.sv
// Upstream clock-speed controller for the CPU clock mux. Decodes each 65816
// bus cycle, requests HS or LS clock from the mux, stalls the CPU through
// cpu_rdy until the mux acknowledges, and flags a sticky error if it never does.
// Optional feature macro: CLKDIV_REG_EN enables the write-only speed control
// register (divider select + force-LS bit) at DIVREG_ADDR.
module hsclk_sel_ctrl
    import beeb816_clk_pkg::*;
#(
    parameter logic [7:0]  IO_LO          = IO_LO_DEF,
    parameter logic [7:0]  IO_HI          = IO_HI_DEF,
    parameter int unsigned HOLD_CYCLES    = HOLD_CYCLES_DEF,
    parameter int unsigned SWITCH_TIMEOUT = SWITCH_TIMEOUT_DEF,
    parameter logic [1:0]  DEFAULT_DIV    = DEFAULT_DIV_DEF,
    parameter logic [23:0] DIVREG_ADDR    = DIVREG_ADDR_DEF
) (
    input  logic        cpuclk_r,
    input  logic        rst_b,
    input  logic [23:0] addr,
    input  logic        vda,
    input  logic        vpa,
    input  logic        rnw,
    input  logic [7:0]  data_in,
    input  logic        hsclk_selected,
    input  logic        lsclk_selected,
    output logic        hsclk_sel,
    output logic [1:0]  cpuclk_div_sel,
    output logic        cpu_rdy,
    output logic        switch_err
);

    localparam int unsigned       HOLD_W    = ctr_width(HOLD_CYCLES);
    localparam int unsigned       TMO_W     = ctr_width(SWITCH_TIMEOUT);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(SWITCH_TIMEOUT);

    clk_state_e        r_state;
    clk_state_e        w_state_nxt;
    logic [HOLD_W-1:0] r_hold;
    logic [HOLD_W-1:0] w_hold_nxt;
    logic [TMO_W-1:0]  r_tmo;
    logic [TMO_W-1:0]  w_tmo_nxt;
    logic              r_err;
    logic              w_err_nxt;
    logic [1:0]        r_div;
    logic [1:0]        w_div_pend;
    logic              w_force_ls;
    logic              w_ls_ack_s;
    logic              w_io_hit;
    logic              w_slow;
    logic              w_hsclk_sel;
    logic              w_rdy;

    // The LS acknowledge comes from a latch in the mux, so resynchronise it.
    clk_sync2 u_ls_sync (
        .cpuclk_r (cpuclk_r),
        .rst_b    (rst_b),
        .i_d      (lsclk_selected),
        .o_q      (w_ls_ack_s)
    );

    // A valid bank-0 access to the IO pages must run on the LS clock.
    assign w_io_hit = (vda | vpa) && (addr[23:16] == 8'h00) &&
                      (addr[15:8] >= IO_LO) && (addr[15:8] <= IO_HI);
    assign w_slow   = w_io_hit | w_force_ls;

`ifdef CLKDIV_REG_EN
    logic       r_div_pend;
    logic [1:0] r_div_pend_val;
    logic       r_force_ls;
    logic       w_reg_wr;

    // Only a completed (rdy) data write hits the register.
    assign w_reg_wr = vda & ~rnw & w_rdy & (addr == DIVREG_ADDR);

    // Speed control register: pending divider and force-LS bit.
    always_ff @(posedge cpuclk_r or negedge rst_b) begin
        if (!rst_b) begin
            r_div_pend_val <= DEFAULT_DIV;
            r_force_ls     <= 1'b0;
        end else if (w_reg_wr) begin
            r_div_pend_val <= data_in[1:0];
            r_force_ls     <= data_in[7];
        end
    end

    // Keep a one-bit alias so both builds present the same pending-value net.
    assign r_div_pend = 1'b0;
    assign w_div_pend = r_div_pend_val;
    assign w_force_ls = r_force_ls;

    logic w_unused_reg;
    assign w_unused_reg = ^{r_div_pend, data_in[6:2]};
`else
    assign w_div_pend = DEFAULT_DIV;
    assign w_force_ls = 1'b0;

    // Register interface inputs are unused without the control register.
    logic w_unused_bus;
    assign w_unused_bus = ^{data_in, rnw, addr[7:0], DIVREG_ADDR};
`endif

    // Next-state, counter and output decode for the clock-switch FSM.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned, which would otherwise infer a latch.
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        w_tmo_nxt   = r_tmo;
        w_err_nxt   = r_err;
        w_hsclk_sel = 1'b0;
        w_rdy       = 1'b1;

        unique case (r_state)
            HS: begin
                w_hsclk_sel = 1'b1;
                if (w_slow) begin
                    w_state_nxt = SW_LS;
                    w_tmo_nxt   = '0;
                end
            end
            SW_LS: begin
                w_rdy = 1'b0;
                if (w_ls_ack_s && !hsclk_selected) begin
                    w_state_nxt = LS;
                    w_hold_nxt  = HOLD_LOAD;
                end else if (r_tmo == TMO_LAST) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = LS;
                    w_hold_nxt  = HOLD_LOAD;
                end else begin
                    w_tmo_nxt = r_tmo + 1'b1;
                end
            end
            LS: begin
                // A slow access always restarts the hold-off, even at hold==1.
                if (w_slow) begin
                    w_hold_nxt = HOLD_LOAD;
                end else if (r_hold == '0) begin
                    w_state_nxt = SW_HS;
                    w_tmo_nxt   = '0;
                end else begin
                    w_hold_nxt = r_hold - 1'b1;
                end
            end
            SW_HS: begin
                w_hsclk_sel = 1'b1;
                w_rdy       = 1'b0;
                // A slow access pending here is handled from HS (no LS bypass).
                if (hsclk_selected) begin
                    w_state_nxt = HS;
                end else if (r_tmo == TMO_LAST) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = LS;
                    w_hold_nxt  = HOLD_LOAD;
                end else begin
                    w_tmo_nxt = r_tmo + 1'b1;
                end
            end
            default: begin
                w_state_nxt = LS;
                w_hold_nxt  = HOLD_LOAD;
            end
        endcase
    end

    // State, counters and sticky error; reset returns straight to LS.
    always_ff @(posedge cpuclk_r or negedge rst_b) begin
        if (!rst_b) begin
            r_state <= LS;
            r_hold  <= HOLD_LOAD;
            r_tmo   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_hold  <= w_hold_nxt;
            r_tmo   <= w_tmo_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // The HS divider may only change while the mux is running the LS clock.
    always_ff @(posedge cpuclk_r or negedge rst_b) begin
        if (!rst_b) begin
            r_div <= DEFAULT_DIV;
        end else if (r_state == LS) begin
            r_div <= w_div_pend;
        end
    end

    assign hsclk_sel      = w_hsclk_sel;
    assign cpu_rdy        = w_rdy;
    assign cpuclk_div_sel = r_div;
    assign switch_err     = r_err;

endmodule

// File: tb/tb_hsclk_sel_ctrl.sv
// Self-checking bench for hsclk_sel_ctrl: a directed vector table, hand-written
// sequences for timeout / divider / async reset, then random bus traffic
// against a cycle-level behavioural model. Honours CLKDIV_REG_EN.
module tb_hsclk_sel_ctrl;

    localparam logic [7:0]  IO_LO    = 8'hFC;
    localparam logic [7:0]  IO_HI    = 8'hFE;
    localparam int          HOLD     = 4;
    localparam int          TMO      = 63;
    localparam logic [1:0]  DEF_DIV  = 2'b00;
    localparam logic [23:0] DIVREG   = 24'hFF00FF;
    localparam logic [23:0] FETCH    = 24'h008000;

    logic        cpuclk_r = 1'b0;
    logic        rst_b;
    logic [23:0] addr;
    logic        vda, vpa, rnw;
    logic [7:0]  data_in;
    logic        hs_ack, ls_ack;
    logic        hsclk_sel, cpu_rdy, switch_err;
    logic [1:0]  cpuclk_div_sel;

    int n_vec  = 0;
    int n_miss = 0;

    hsclk_sel_ctrl #(
        .IO_LO          (IO_LO),
        .IO_HI          (IO_HI),
        .HOLD_CYCLES    (HOLD),
        .SWITCH_TIMEOUT (TMO),
        .DEFAULT_DIV    (DEF_DIV),
        .DIVREG_ADDR    (DIVREG)
    ) dut (
        .cpuclk_r       (cpuclk_r),
        .rst_b          (rst_b),
        .addr           (addr),
        .vda            (vda),
        .vpa            (vpa),
        .rnw            (rnw),
        .data_in        (data_in),
        .hsclk_selected (hs_ack),
        .lsclk_selected (ls_ack),
        .hsclk_sel      (hsclk_sel),
        .cpuclk_div_sel (cpuclk_div_sel),
        .cpu_rdy        (cpu_rdy),
        .switch_err     (switch_err)
    );

    always #5 cpuclk_r = ~cpuclk_r;

    // ---------------- reference model (mux-request view) ----------------
    // m_fast: HS clock requested; m_busy: waiting for the mux to confirm.
    bit         m_fast, m_busy, m_err, m_force;
    int         m_hold, m_wait;
    logic [1:0] m_div, m_pend;
    bit         m_lsq[$];

    function automatic bit io_access(input logic [23:0] a, input logic da, input logic pa);
        return (da || pa) && (a[23:16] == 8'h00) && (a[15:8] >= IO_LO) && (a[15:8] <= IO_HI);
    endfunction

    task automatic model_reset();
        m_fast = 0; m_busy = 0; m_err = 0; m_force = 0;
        m_hold = HOLD; m_wait = 0;
        m_div = DEF_DIV; m_pend = DEF_DIV;
        m_lsq = {1'b1, 1'b1};
    endtask

    task automatic model_edge();
        bit ack_s, rdy, slow, wr;
        ack_s = m_lsq.pop_front();
        m_lsq.push_back(ls_ack);
        rdy  = !m_busy;
        slow = io_access(addr, vda, vpa) || m_force;
`ifdef CLKDIV_REG_EN
        wr = vda && !rnw && rdy && (addr == DIVREG);
`else
        wr = 0;
`endif
        if (!m_busy && !m_fast) m_div = m_pend;
        if (m_busy) begin
            if (m_fast ? hs_ack : (ack_s && !hs_ack)) begin
                m_busy = 0;
                if (!m_fast) m_hold = HOLD;
            end else if (m_wait == TMO) begin
                m_err = 1; m_fast = 0; m_busy = 0; m_hold = HOLD;
            end else begin
                m_wait++;
            end
        end else if (m_fast) begin
            if (slow) begin m_fast = 0; m_busy = 1; m_wait = 0; end
        end else begin
            if (slow)             m_hold = HOLD;
            else if (m_hold == 0) begin m_fast = 1; m_busy = 1; m_wait = 0; end
            else                  m_hold--;
        end
        if (wr) begin m_pend = data_in[1:0]; m_force = data_in[7]; end
    endtask

    // ---------------- mux environment ----------------
    bit   env_on = 0, env_rand = 0, blk_hs = 0, blk_ls = 0;
    logic env_tgt = 1'b0;
    int   env_cnt = 2, env_lat = 2;

    task automatic env_update();
        if (hsclk_sel !== env_tgt) begin
            env_tgt = hsclk_sel; env_cnt = 0; hs_ack = 0; ls_ack = 0;
            if (env_rand) begin
                env_lat = $urandom_range(1, 4);
                blk_hs  = ($urandom_range(0, 49) == 0);
                blk_ls  = ($urandom_range(0, 49) == 0);
            end
        end else if (env_cnt < env_lat) begin
            env_cnt++;
            if (env_cnt == env_lat) begin
                if (env_tgt) hs_ack = !blk_hs;
                else         ls_ack = !blk_ls;
            end
        end
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_bus(input logic [23:0] a, input logic da, input logic pa,
                           input logic rw, input logic [7:0] d);
        // NOTE: stimulus is driven with blocking assignments one time unit
        // after the edge, so DUT and model both see stable values at the next edge.
        addr = a; vda = da; vpa = pa; rnw = rw; data_in = d;
    endtask

    // One clock: model steps on the edge, outputs compared 1 unit later.
    task automatic tick();
        @(posedge cpuclk_r);
        model_edge();
        #1;
        check("model", {hsclk_sel, cpu_rdy, cpuclk_div_sel, switch_err},
                       {m_fast, !m_busy, m_div, m_err});
        if (env_on) env_update();
    endtask

    task automatic wait_state(input string name, input logic sel, input logic rdy, input int budget);
        bit hit = 0;
        for (int i = 0; i < budget && !hit; i++) begin
            tick();
            hit = (hsclk_sel === sel) && (cpu_rdy === rdy);
        end
        check(name, hit, 1);
    endtask

    task automatic do_reset();
        rst_b = 1'b0;
        set_bus(24'h0, 0, 0, 1, 8'h00);
        hs_ack = 0; ls_ack = 1;
        env_tgt = 1'b0; env_lat = 2; env_cnt = 2; blk_hs = 0; blk_ls = 0;
        model_reset();
        repeat (2) @(posedge cpuclk_r);
        #1;
        check("reset_state", {hsclk_sel, cpu_rdy, cpuclk_div_sel, switch_err},
                             {1'b0, 1'b1, DEF_DIV, 1'b0});
        rst_b = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [23:0] a;
        logic        da, pa, hs, ls;
        logic        exp_sel, exp_rdy;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [23:0] a, input logic da, input logic pa,
                       input logic hs, input logic ls, input logic es, input logic er);
        vec_t v;
        v.a = a; v.da = da; v.pa = pa; v.hs = hs; v.ls = ls; v.exp_sel = es; v.exp_rdy = er;
        tbl.push_back(v);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [23:0] a;
        int          cnt;

        do_reset();

        // Reset LS, fetches count the hold-off down, switch to HS.
        for (int i = 0; i < 4; i++) add(FETCH, 0, 1, 0, 1, 0, 1);
        add(FETCH, 0, 1, 0, 1, 1, 0);
        add(FETCH, 0, 1, 0, 0, 1, 0);
        add(FETCH, 0, 1, 0, 0, 1, 0);
        add(FETCH, 0, 1, 1, 0, 1, 1);
        // Near-miss decodes stay in HS: other bank, idle, pages FB and FF.
        add(24'h01FE40, 1, 0, 1, 0, 1, 1);
        add(24'h00FE40, 0, 0, 1, 0, 1, 1);
        add(24'h00FB00, 0, 1, 1, 0, 1, 1);
        add(24'h00FF00, 1, 0, 1, 0, 1, 1);
        // Page FC is slow: stall, wait for synchronised LS ack with HS ack low.
        add(24'h00FC00, 0, 1, 1, 0, 0, 0);
        add(24'h00FC00, 0, 1, 0, 0, 0, 0);
        add(24'h00FC00, 0, 1, 0, 1, 0, 0);
        add(24'h00FC00, 0, 1, 0, 1, 0, 0);
        add(24'h00FC00, 0, 1, 1, 1, 0, 0);
        add(24'h00FC00, 0, 1, 0, 1, 0, 1);
        add(24'h00FC00, 0, 1, 0, 1, 0, 1);
        // Slow accesses sprinkled in LS keep reloading the hold-off,
        // including one arriving when only one hold cycle is left.
        for (int i = 0; i < 11; i++) begin
            if (i == 2 || i == 6) add(24'h00FD12, 1, 0, 0, 1, 0, 1);
            else                  add(FETCH, 0, 1, 0, 1, 0, 1);
        end
        add(FETCH, 0, 1, 0, 1, 1, 0);

        foreach (tbl[i]) begin
            set_bus(tbl[i].a, tbl[i].da, tbl[i].pa, 1'b1, 8'h00);
            hs_ack = tbl[i].hs; ls_ack = tbl[i].ls;
            tick();
            check($sformatf("table[%0d]", i), {hsclk_sel, cpu_rdy}, {tbl[i].exp_sel, tbl[i].exp_rdy});
        end

        // Hand the acks over to the mux environment (currently in SW_HS).
        env_on = 1; env_tgt = 1'b1; env_cnt = 0; hs_ack = 0; ls_ack = 0;
        set_bus(FETCH, 0, 1, 1, 8'h00);
        wait_state("reach_hs", 1, 1, 40);

`ifdef CLKDIV_REG_EN
        // Divider write in HS only takes effect on a later LS cycle.
        set_bus(DIVREG, 1, 0, 0, 8'h03);
        tick();
        set_bus(FETCH, 0, 1, 1, 8'h00);
        repeat (3) tick();
        check("div_held_in_hs", cpuclk_div_sel, DEF_DIV);
        set_bus(24'h00FE40, 1, 0, 1, 8'h00);
        wait_state("reach_ls_div", 0, 1, 40);
        check("div_not_on_entry", cpuclk_div_sel, DEF_DIV);
        tick();
        check("div_applied", cpuclk_div_sel, 2'b11);

        // Force-LS keeps fast fetches on the LS clock until cleared.
        set_bus(DIVREG, 1, 0, 0, 8'h83);
        tick();
        set_bus(FETCH, 0, 1, 1, 8'h00);
        repeat (20) tick();
        check("force_ls_stays", {hsclk_sel, cpu_rdy}, 2'b01);
        set_bus(DIVREG, 1, 0, 0, 8'h03);
        tick();
        set_bus(FETCH, 0, 1, 1, 8'h00);
        wait_state("force_release_hs", 1, 1, 40);
`endif

        // Mux never confirms LS: timeout, sticky error, fall back to LS.
        blk_ls = 1;
        set_bus(24'h00FE40, 1, 0, 1, 8'h00);
        tick();
        check("enter_sw_ls", {hsclk_sel, cpu_rdy}, 2'b00);
        cnt = 0;
        while (!cpu_rdy && cnt < 200) begin
            tick();
            cnt++;
        end
        check("timeout_cycles", cnt, TMO + 1);
        check("timeout_state", {switch_err, hsclk_sel, cpu_rdy}, 3'b101);
        blk_ls = 0;

        // Stall in SW_HS, then assert reset mid-cycle: outputs drop at once.
        blk_hs = 1;
        set_bus(FETCH, 0, 1, 1, 8'h00);
        wait_state("reach_sw_hs", 1, 0, 40);
        check("err_sticky", switch_err, 1);
        #2;
        rst_b = 1'b0;
        #1;
        check("async_reset", {hsclk_sel, cpu_rdy, cpuclk_div_sel, switch_err},
                             {1'b0, 1'b1, DEF_DIV, 1'b0});
        do_reset();

        // Random traffic against the model; the CPU holds its cycle while stalled.
        env_rand = 1;
        for (int n = 0; n < 3000; n++) begin
            if (!m_busy) begin
                int r;
                r = $urandom_range(0, 99);
                a[23:16] = (r < 70) ? 8'h00 : 8'($urandom_range(0, 255));
                case ($urandom_range(0, 3))
                    0:       a[15:8] = 8'($urandom_range(IO_LO, IO_HI));
                    1:       a[15:8] = $urandom_range(0, 1) ? 8'hFB : 8'hFF;
                    default: a[15:8] = 8'($urandom_range(0, 255));
                endcase
                a[7:0] = 8'($urandom_range(0, 255));
                set_bus(a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), 8'($urandom_range(0, 127)));
`ifdef CLKDIV_REG_EN
                if ($urandom_range(0, 19) == 0) begin
                    data_in = 8'($urandom_range(0, 127));
                    if ($urandom_range(0, 2) == 0) data_in[7] = 1'b1;
                    set_bus(DIVREG, 1, 0, 0, data_in);
                end
`endif
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
